// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main control FSM:
// opcodes, state codes and datapath mux-select encodings.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_t;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: one state register,
// combinational next-state logic and Moore output decode.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t state;
  state_t state_next;
  logic   rdy;

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = S_EXEC;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDIEX;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    pc_src     = PCSRC_ALU;
    illegal    = 1'b0;
    state_dbg  = state;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = rdy;
        pc_en     = rdy;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
      end
      S_JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_en  = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
    // Reset gates every output combinationally so an abort drops them at once.
    if (!rst_n) begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = '0;
      alu_op     = '0;
      pc_src     = '0;
      illegal    = 1'b0;
      state_dbg  = '0;
    end
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory and write-back over several cycles, and waits on a memory-ready handshake. It drives every datapath mux-select and write-enable, and flags unsupported opcodes. It sits beside the MIPS datapath and replaces the single-cycle combinational decoder.

Parameters:
MEM_HANDSHAKE, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is treated as constant 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from instruction register
zero  in  1  ALU zero flag, used in BRANCH state
mem_ready  in  1  memory completes read/write this cycle
pc_en  out  1  PC load enable (= pc_write | (branch & zero))
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal  out  1  one-cycle pulse on unsupported opcode
state_dbg  out  4  current state encoding

Behaviour:
- Reset: while rst_n = 0, state = FETCH and every output is forced to 0 (including mem_read). The first cycle after deassertion is FETCH.
- Outputs are Moore, decoded from state. The only exceptions are pc_en and ir_write, which also qualify on mem_ready or zero as noted below.
- Any output not listed in a state is 0.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12-15 are unreachable and recover to FETCH.
- FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00. If mem_ready: ir_write = 1, pc_en = 1, next state DECODE; otherwise hold in FETCH with ir_write = pc_en = 0.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode:
  - 000000 (R-type) -> EXEC
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDIEX
  - any other opcode -> FETCH, with illegal = 1 for this cycle only
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state MEMRD for lw, MEMWR for sw (opcode is held stable by the IR).
- MEMRD: mem_read = 1, iord = 1. On mem_ready -> MEMWB; otherwise hold.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next state FETCH.
- MEMWR: mem_write = 1, iord = 1. On mem_ready -> FETCH; otherwise hold. mem_write stays high for the whole wait.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next state ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next state FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01, pc_en = zero. Next state FETCH.
- JUMP: pc_src = 10, pc_en = 1. Next state FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next state FETCH.
- Instruction latency, with zero wait states: lw 5 cycles; sw, R-type and addi 4; beq and j 3. Each cycle mem_ready is low in a memory state adds one cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction aborts it immediately: all outputs drop in the same cycle, asynchronously, and no partial write-enable pulse is emitted afterwards.
- mem_read and mem_write are never high in the same cycle.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - the 4-bit state enum
  - alu_op, alu_src_b and pc_src encodings
- No sub-module: a single state register plus combinational next-state and output decode.

Test Plan:
- Reset release, then R-type (opcode 0), mem_ready held 1 -> states 0,1,6,7,0. reg_write = 1 and reg_dst = 1 only in state 7. pc_en = 1 only in cycle 1.
- lw (100011), mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. mem_to_reg = 1 with reg_write = 1 in state 4. iord = 1 throughout state 3.
- sw (101011) -> mem_write high in state 5 until mem_ready, then FETCH. reg_write is never asserted.
- beq (000100) with zero = 1 -> pc_en = 1 and pc_src = 01 in state 8. Repeat with zero = 0 -> pc_en = 0.
- j then opcode 111111 -> j: pc_en = 1 with pc_src = 10 in state 9. 111111: illegal pulses for exactly one cycle in DECODE, then state 0.
- rst_n pulled low during MEMWR with mem_write = 1 -> mem_write = 0 immediately. After release, FETCH with mem_read = 1 on the first clock.
